reglk_init_seq: RTL and testbench
=================================

# reglk_init_seq

Boot-time sequencer for the register-lock bank. After reset and a software/boot-ROM start pulse, it writes a compile-time set of lock words into the bank through its word-addressed request/grant port. Optionally, it reads every word back and compares it with the programmed value. It then asserts a sticky lock level, which drives the bank's write-lock control, so the lock map cannot be rewritten until reset or a JTAG unlock. It sits between the SoC boot controller and the lock bank's register port, in the same clock domain.

## Interface
Parameters:
- `NB_WORDS`, 6, number of 32-bit lock words in the bank (1..32)
- `WORD_W`, 32, width of one lock word
- `INIT_VAL`, {NB_WORDS{32'hffffffff}}, packed initial words; word i = INIT_VAL[i*WORD_W +: WORD_W]
- `TIMEOUT`, 255, maximum cycles waiting on cfg_gnt_i or cfg_rvalid_i (1..255)

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `start_i` in 1: start pulse; honoured in IDLE and ERROR only
- `jtag_unlock_i` in 1: abort/unlock; highest priority
- `cfg_req_o` out 1: bank access request
- `cfg_we_o` out 1: 1 = write, 0 = read
- `cfg_addr_o` out 8: byte address {idx[4:0], 3'b000}
- `cfg_wdata_o` out 64: write data, zero-extended word
- `cfg_gnt_i` in 1: request accepted this cycle
- `cfg_rvalid_i` in 1: read data valid
- `cfg_rdata_i` in 64: read data; bits [WORD_W-1:0] compared
- `busy_o` out 1: sequence in progress
- `done_o` out 1: sequence completed, level
- `lock_o` out 1: write-lock to bank, level
- `err_o` out 1: sequence failed, level
- `err_code_o` out 2: 0 none, 1 timeout, 2 readback mismatch
- `err_idx_o` out 5: word index at failure

## Operation
- States: IDLE, WRITE, RD_REQ, RD_WAIT, DONE, ERROR. A 5-bit word index `idx` and an 8-bit timeout counter `tcnt` track progress.
- Reset values:
  - State is IDLE; idx and tcnt are 0.
  - All outputs are 0, including lock_o, which is open.
- IDLE or ERROR, start_i=1:
  - Go to WRITE with idx=0 and tcnt=0.
  - Clear err_o, err_code_o and err_idx_o.
- WRITE:
  - Drive cfg_req_o=1, cfg_we_o=1, addr and wdata from idx.
  - Hold addr and wdata stable until grant.
  - On cfg_gnt_i: if idx==NB_WORDS-1, set idx=0 and go to RD_REQ (or DONE without verify). Otherwise idx+1.
  - tcnt resets at every grant.
- RD_REQ: drive cfg_req_o=1, cfg_we_o=0; on cfg_gnt_i go to RD_WAIT.
- RD_WAIT:
  - Drive cfg_req_o=0.
  - On cfg_rvalid_i with rdata[WORD_W-1:0]==INIT word: advance idx, or go to DONE after the last word.
  - On cfg_rvalid_i with any other value: go to ERROR with code 2 and err_idx=idx.
- Timeout: in WRITE, RD_REQ or RD_WAIT, tcnt counts each cycle without the awaited gnt/rvalid. When tcnt reaches TIMEOUT, go to ERROR with code 1 and err_idx=idx.
- DONE:
  - Hold done_o=1 and lock_o=1.
  - start_i is ignored, so re-programming is impossible while locked.
- ERROR: err_o=1 and lock_o=0; start_i retries.
- jtag_unlock_i=1 in any state:
  - Next state is IDLE and all outputs are cleared.
  - This takes priority over start_i, grants and rvalid in the same cycle.
- busy_o=1 in WRITE, RD_REQ and RD_WAIT.
- cfg_req_o is never asserted in IDLE, DONE or ERROR.

## Timing
- All outputs are registered.
- start_i is sampled at edge E; cfg_req_o rises in the cycle after E.
- With cfg_gnt_i tied high, each write takes 1 cycle, so writes occupy cycles E+1..E+NB_WORDS.
- Without verify, done_o and lock_o rise at E+NB_WORDS+1 (E+7 for default parameters).
- With verify, and rvalid one cycle after grant, each read takes 2 cycles; done_o and lock_o rise at E+3·NB_WORDS+1 (E+19).
- Grant and timeout in the same cycle: the grant wins.
- Asynchronous reset mid-sequence: outputs return to reset values immediately. The partially written bank is not touched; the bank's own reset handles it.

## Configuration
- `REGLK_SEQ_VERIFY_EN` defined:
  - RD_REQ and RD_WAIT are compiled in.
  - Readback compare runs before lock.
  - err_code 2 is reachable.
- `REGLK_SEQ_VERIFY_EN` undefined:
  - WRITE goes directly to DONE after the last grant.
  - cfg_we_o is constant 1 whenever cfg_req_o=1.
  - err_code_o is only ever 0 or 1.

## Test plan
- Reset, then start_i pulse, gnt=1, rvalid echoing the written value → 6 writes to addrs 0x00..0x28 with wdata 0xffffffff, 6 reads, done_o=lock_o=1 at E+19, err_o=0.
- Grant withheld on word 2 for 255 cycles → err_o=1, err_code_o=1, err_idx_o=2, lock_o=0; a following start_i restarts at addr 0x00.
- Readback of word 4 returns 0x0 → err_code_o=2, err_idx_o=4, lock_o=0.
- start_i pulsed in DONE → no cfg_req_o; outputs unchanged.
- jtag_unlock_i asserted mid-WRITE at idx=3 together with cfg_gnt_i → IDLE next cycle, cfg_req_o=0, busy_o=0; with done_o=1, it clears lock_o.
- Build with REGLK_SEQ_VERIFY_EN undefined and gnt=1 → done_o at E+7, no read requests issued.

Source files
------------

// File: rtl/reglk_init_seq_if.sv
// Word-addressed request/grant register port between the lock-init sequencer and the lock bank.
// Latency: none; this is a plain signal bundle.
// Backpressure: the master holds req/addr/wdata until gnt; read data returns on rvalid.
interface reglk_init_seq_if;
    logic        cfg_req_o;
    logic        cfg_we_o;
    logic [7:0]  cfg_addr_o;
    logic [63:0] cfg_wdata_o;
    logic        cfg_gnt_i;
    logic        cfg_rvalid_i;
    logic [63:0] cfg_rdata_i;

    modport master (
        output cfg_req_o, cfg_we_o, cfg_addr_o, cfg_wdata_o,
        input  cfg_gnt_i, cfg_rvalid_i, cfg_rdata_i
    );

    modport slave (
        input  cfg_req_o, cfg_we_o, cfg_addr_o, cfg_wdata_o,
        output cfg_gnt_i, cfg_rvalid_i, cfg_rdata_i
    );
endinterface

// File: rtl/reglk_init_seq.sv
// Boot-time sequencer: writes INIT_VAL into the lock bank, optionally reads it back, then raises a sticky lock.
// Latency: request rises one cycle after start; one cycle per granted write, two per verified read.
// Backpressure: waits on gnt/rvalid up to TIMEOUT cycles, then stops in ERROR. Readback: define REGLK_SEQ_VERIFY_EN.
module reglk_init_seq #(
    parameter int                         NB_WORDS = 6,
    parameter int                         WORD_W   = 32,
    parameter logic [NB_WORDS*WORD_W-1:0] INIT_VAL = {(NB_WORDS*WORD_W){1'b1}},
    parameter int                         TIMEOUT  = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             jtag_unlock_i,
    reglk_init_seq_if.master cfg,
    output logic             busy_o,
    output logic             done_o,
    output logic             lock_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [4:0]       err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NB_WORDS - 1);
    localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
`ifdef REGLK_SEQ_VERIFY_EN
    localparam logic [1:0] ERR_RDBK = 2'd2;
`endif

    // Lock word idx of INIT_VAL, zero-extended to the 64-bit bus.
    function automatic logic [63:0] f_word(input logic [4:0] idx);
        logic [63:0] w_val;
        w_val = '0;
        w_val[WORD_W-1:0] = INIT_VAL[int'(idx)*WORD_W +: WORD_W];
        return w_val;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_tcnt, w_tcnt_nxt, w_tcnt_inc;
    logic [1:0]  r_err_code, w_err_code_nxt;
    logic [4:0]  r_err_idx, w_err_idx_nxt;
    logic        w_tmo;
    logic        r_req, r_we, r_busy, r_done, r_lock, r_err;
    logic [7:0]  r_addr;
    logic [63:0] r_wdata;
    logic        w_req_nxt, w_we_nxt;
    logic [7:0]  w_addr_nxt;
    logic [63:0] w_wdata_nxt;
`ifdef REGLK_SEQ_VERIFY_EN
    logic [63:0] w_word_cur;
`endif
    logic        w_unused;

    // Only the low WORD_W read-data bits are compared; the rest of the read port is intentionally ignored.
    assign w_unused = ^{cfg.cfg_rvalid_i, cfg.cfg_rdata_i};

    // Next-state, progress counters and next registered outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tcnt_nxt     = r_tcnt;
        w_err_code_nxt = r_err_code;
        w_err_idx_nxt  = r_err_idx;
        w_tcnt_inc     = r_tcnt + 8'd1;
        w_tmo          = (w_tcnt_inc == TMO_MAX);
`ifdef REGLK_SEQ_VERIFY_EN
        w_word_cur     = f_word(r_idx);
`endif
        if (jtag_unlock_i) begin
            w_state_nxt    = S_IDLE;
            w_idx_nxt      = '0;
            w_tcnt_nxt     = '0;
            w_err_code_nxt = ERR_NONE;
            w_err_idx_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start_i) begin
                        w_state_nxt    = S_WRITE;
                        w_idx_nxt      = '0;
                        w_tcnt_nxt     = '0;
                        w_err_code_nxt = ERR_NONE;
                        w_err_idx_nxt  = '0;
                    end
                end
                S_WRITE: begin
                    if (cfg.cfg_gnt_i) begin
                        w_tcnt_nxt = '0;
                        if (r_idx == LAST_IDX) begin
                            w_idx_nxt = '0;
`ifdef REGLK_SEQ_VERIFY_EN
                            w_state_nxt = S_RD_REQ;
`else
                            w_state_nxt = S_DONE;
`endif
                        end else begin
                            w_idx_nxt = r_idx + 5'd1;
                        end
                    end else if (w_tmo) begin
                        w_state_nxt    = S_ERROR;
                        w_tcnt_nxt     = '0;
                        w_err_code_nxt = ERR_TMO;
                        w_err_idx_nxt  = r_idx;
                    end else begin
                        w_tcnt_nxt = w_tcnt_inc;
                    end
                end
`ifdef REGLK_SEQ_VERIFY_EN
                S_RD_REQ: begin
                    if (cfg.cfg_gnt_i) begin
                        w_state_nxt = S_RD_WAIT;
                        w_tcnt_nxt  = '0;
                    end else if (w_tmo) begin
                        w_state_nxt    = S_ERROR;
                        w_tcnt_nxt     = '0;
                        w_err_code_nxt = ERR_TMO;
                        w_err_idx_nxt  = r_idx;
                    end else begin
                        w_tcnt_nxt = w_tcnt_inc;
                    end
                end
                S_RD_WAIT: begin
                    if (cfg.cfg_rvalid_i) begin
                        w_tcnt_nxt = '0;
                        if (cfg.cfg_rdata_i[WORD_W-1:0] != w_word_cur[WORD_W-1:0]) begin
                            w_state_nxt    = S_ERROR;
                            w_err_code_nxt = ERR_RDBK;
                            w_err_idx_nxt  = r_idx;
                        end else if (r_idx == LAST_IDX) begin
                            w_state_nxt = S_DONE;
                            w_idx_nxt   = '0;
                        end else begin
                            w_state_nxt = S_RD_REQ;
                            w_idx_nxt   = r_idx + 5'd1;
                        end
                    end else if (w_tmo) begin
                        w_state_nxt    = S_ERROR;
                        w_tcnt_nxt     = '0;
                        w_err_code_nxt = ERR_TMO;
                        w_err_idx_nxt  = r_idx;
                    end else begin
                        w_tcnt_nxt = w_tcnt_inc;
                    end
                end
`endif
                default: begin
                    // DONE holds (start ignored while locked); unreachable codes stay put.
                end
            endcase
        end

        w_req_nxt   = (w_state_nxt == S_WRITE) || (w_state_nxt == S_RD_REQ);
        w_we_nxt    = (w_state_nxt == S_WRITE);
        w_addr_nxt  = w_req_nxt ? {w_idx_nxt, 3'b000} : 8'h00;
        w_wdata_nxt = w_we_nxt ? f_word(w_idx_nxt) : 64'h0;
    end

    // State, progress and registered outputs; async reset opens the lock immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_tcnt     <= '0;
            r_err_code <= ERR_NONE;
            r_err_idx  <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_err_code <= w_err_code_nxt;
            r_err_idx  <= w_err_idx_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_busy     <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_RD_REQ) || (w_state_nxt == S_RD_WAIT);
            r_done     <= (w_state_nxt == S_DONE);
            r_lock     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_ERROR);
        end
    end

    assign cfg.cfg_req_o   = r_req;
    assign cfg.cfg_we_o    = r_we;
    assign cfg.cfg_addr_o  = r_addr;
    assign cfg.cfg_wdata_o = r_wdata;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign lock_o          = r_lock;
    assign err_o           = r_err;
    assign err_code_o      = r_err_code;
    assign err_idx_o       = r_err_idx;

endmodule

// File: tb/tb_reglk_init_seq.sv
// Bench for reglk_init_seq: bank model answering gnt/rvalid, bus scoreboard and status checks.
// Latency: done expected 7 cycles after start (19 with readback), timeout error 258 cycles after start.
// Backpressure: the bank model withholds grant on a chosen address to force the timeout.
module tb_reglk_init_seq;
    localparam int NB      = 6;
    localparam int TMO     = 255;
`ifdef REGLK_SEQ_VERIFY_EN
    localparam int NB_RD   = NB;
`else
    localparam int NB_RD   = 0;
`endif
    localparam int DONE_CYC = (NB_RD != 0) ? 3*NB + 1 : NB + 1;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [63:0] wdata;
    } txn_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       jtag  = 1'b0;
    logic       busy, done, lock, err;
    logic [1:0] code;
    logic [4:0] eidx;

    int   n_cmp = 0;
    int   n_bad = 0;
    txn_t exp_q[$];

    logic       hold_en     = 1'b0;
    logic [7:0] hold_addr   = 8'h00;
    int         bad_idx     = -1;
    logic       rd_pend     = 1'b0;
    logic [4:0] rd_pend_idx = 5'd0;

    reglk_init_seq_if bus();

    reglk_init_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .jtag_unlock_i (jtag),
        .cfg           (bus),
        .busy_o        (busy),
        .done_o        (done),
        .lock_o        (lock),
        .err_o         (err),
        .err_code_o    (code),
        .err_idx_o     (eidx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic b, input logic d, input logic l,
                              input logic e, input logic [1:0] c, input logic [4:0] i);
        chk({name, "_busy"}, busy, b);
        chk({name, "_done"}, done, d);
        chk({name, "_lock"}, lock, l);
        chk({name, "_err"},  err,  e);
        chk({name, "_code"}, code, c);
        chk({name, "_idx"},  eidx, i);
    endtask

    task automatic push_run(input int n_wr, input int n_rd);
        txn_t t;
        for (int i = 0; i < n_wr; i++) begin
            t.we = 1'b1; t.addr = 8'(i * 8); t.wdata = 64'h0000_0000_ffff_ffff;
            exp_q.push_back(t);
        end
        for (int i = 0; i < n_rd; i++) begin
            t.we = 1'b0; t.addr = 8'(i * 8); t.wdata = 64'h0;
            exp_q.push_back(t);
        end
    endtask

    // Leaves the bench in cycle E+1, i.e. just after the edge that sampled start.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Counts cycles from E+1 until done or err shows up; bounded.
    task automatic wait_end(output int cyc);
        cyc = 1;
        while (!(done || err) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Bank model: grant (optionally withheld on one address) and rvalid one cycle after a read grant.
    initial begin
        bus.cfg_gnt_i    = 1'b1;
        bus.cfg_rvalid_i = 1'b0;
        bus.cfg_rdata_i  = 64'h0;
        forever begin
            @(posedge clk); #1;
            bus.cfg_gnt_i    = !(hold_en && bus.cfg_req_o && bus.cfg_addr_o == hold_addr);
            bus.cfg_rvalid_i = rd_pend;
            bus.cfg_rdata_i  = rd_pend ? {32'hdead_beef, (int'(rd_pend_idx) == bad_idx) ? 32'h0 : 32'hffff_ffff}
                                       : 64'h0;
        end
    end

    // Monitor: every accepted request is popped against the scoreboard.
    always @(negedge clk) begin
        txn_t e, a;
        rd_pend = 1'b0;
        if (rst_n && bus.cfg_req_o && bus.cfg_gnt_i) begin
            rd_pend     = !bus.cfg_we_o;
            rd_pend_idx = bus.cfg_addr_o[7:3];
            a.we    = bus.cfg_we_o;
            a.addr  = bus.cfg_addr_o;
            a.wdata = bus.cfg_we_o ? bus.cfg_wdata_o : 64'h0;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bus_txn: got we=%0b addr=%0h, required no request", a.we, a.addr);
            end else begin
                e = exp_q.pop_front();
                chk("bus_txn", a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required completion");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  found;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_req",   bus.cfg_req_o,   1'b0);
        chk("rst_we",    bus.cfg_we_o,    1'b0);
        chk("rst_addr",  bus.cfg_addr_o,  8'h00);
        chk("rst_wdata", bus.cfg_wdata_o, 64'h0);
        chk_status("rst", 0, 0, 0, 0, 2'd0, 5'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sequence
        push_run(NB, NB_RD);
        pulse_start();
        chk("s1_req_rise", bus.cfg_req_o, 1'b1);
        wait_end(cyc);
        chk("s1_done_cycle", cyc, DONE_CYC);
        chk_status("s1_done", 0, 1, 1, 0, 2'd0, 5'd0);

        // start ignored while locked
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk("done_nostart_req", bus.cfg_req_o, 1'b0);
            @(posedge clk); #1;
        end
        chk_status("done_hold", 0, 1, 1, 0, 2'd0, 5'd0);

        // JTAG unlock from DONE
        jtag = 1'b1;
        @(posedge clk); #1 jtag = 1'b0;
        chk_status("jtag_done", 0, 0, 0, 0, 2'd0, 5'd0);

        // Grant withheld on word 2
        hold_addr = 8'h10;
        hold_en   = 1'b1;
        push_run(2, 0);
        pulse_start();
        wait_end(cyc);
        chk("tmo_cycle", cyc, 2 + TMO + 1);
        chk("tmo_req", bus.cfg_req_o, 1'b0);
        chk_status("tmo", 0, 0, 0, 1, 2'd1, 5'd2);

        // Retry from ERROR restarts at word 0
        hold_en = 1'b0;
        push_run(NB, NB_RD);
        pulse_start();
        chk("retry_err_clr",  err,  1'b0);
        chk("retry_code_clr", code, 2'd0);
        chk("retry_addr0",    bus.cfg_addr_o, 8'h00);
        wait_end(cyc);
        chk("retry_done_cycle", cyc, DONE_CYC);
        chk_status("retry", 0, 1, 1, 0, 2'd0, 5'd0);
        jtag = 1'b1;
        @(posedge clk); #1 jtag = 1'b0;

`ifdef REGLK_SEQ_VERIFY_EN
        // Readback mismatch on word 4
        bad_idx = 4;
        push_run(NB, 5);
        pulse_start();
        wait_end(cyc);
        chk("rdbk_cycle", cyc, 17);
        chk_status("rdbk", 0, 0, 0, 1, 2'd2, 5'd4);
        bad_idx = -1;
`endif

        // JTAG unlock together with the grant of word 3
        push_run(4, 0);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.cfg_req_o && bus.cfg_we_o && bus.cfg_addr_o == 8'h18) begin
                found = 1'b1;
                jtag  = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("jtag_wr_found", found, 1'b1);
        @(posedge clk); #1 jtag = 1'b0;
        chk("jtag_wr_req", bus.cfg_req_o, 1'b0);
        chk_status("jtag_wr", 0, 0, 0, 0, 2'd0, 5'd0);

        // Asynchronous reset mid-sequence
        push_run(2, 0);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  bus.cfg_req_o,  1'b0);
        chk("arst_addr", bus.cfg_addr_o, 8'h00);
        chk("arst_busy", busy, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_status("arst", 0, 0, 0, 0, 2'd0, 5'd0);

        // Clean run after reset
        push_run(NB, NB_RD);
        pulse_start();
        wait_end(cyc);
        chk("final_done_cycle", cyc, DONE_CYC);
        chk_status("final", 0, 1, 1, 0, 2'd0, 5'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
